duty_cycle_meter_mc: RTL and testbench

Multi-channel, parametrised gated duty-cycle and edge meter. Over a programmable gate window of GATE_CYCLES sys_clk cycles, each of NUM_CH asynchronous inputs is synchronised and measured for high-cycle count and rising-edge count.
Results latch into output registers with a one-cycle valid strobe. Duty cycle is high_cnt/GATE_CYCLES; frequency is rise_cnt per window. Both divisions are done by the consumer.
Supports single-shot (start pulse) and continuous back-to-back measurement.

---
 rtl/duty_cycle_meter_mc.sv | 148 ++++++++++++++
 tb/tb_duty_cycle_meter_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/duty_cycle_meter_mc.sv
// Gated multi-channel duty-cycle and rising-edge meter.
// Counts high cycles and rising edges per channel over a fixed GATE_CYCLES window.
module duty_cycle_meter_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic                    start,
  input  logic                    continuous,
  output logic                    busy,
  output logic                    meas_valid,
  output logic [NUM_CH*CNT_W-1:0] high_cnt,
  output logic [NUM_CH*CNT_W-1:0] rise_cnt,
  output logic [NUM_CH-1:0]       ovf
);
  // state | meaning
  // IDLE  | waiting for start or continuous; accumulators held at zero
  // GATE  | window open, every channel sampled once per cycle
  // LATCH | accumulators copied to result registers, meas_valid strobed

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t                              state_q, state_d;
  logic [GW-1:0]                       gate_cnt_q, gate_cnt_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
  logic [NUM_CH-1:0]                   prev_q, prev_d;
  logic [NUM_CH-1:0]                   s;
  logic [NUM_CH-1:0][CNT_W-1:0]        acc_h_q, acc_h_d;
  logic [NUM_CH-1:0][CNT_W-1:0]        acc_r_q, acc_r_d;
  logic [NUM_CH-1:0]                   ovf_acc_q, ovf_acc_d;
  logic [NUM_CH-1:0][CNT_W-1:0]        high_q, high_d;
  logic [NUM_CH-1:0][CNT_W-1:0]        rise_q, rise_d;
  logic [NUM_CH-1:0]                   ovf_q, ovf_d;
  logic                                busy_q, busy_d;
  logic                                meas_valid_q, meas_valid_d;

  // synchroniser and previous-sample register run in every state
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign prev_d = s;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    acc_h_d      = acc_h_q;
    acc_r_d      = acc_r_q;
    ovf_acc_d    = ovf_acc_q;
    high_d       = high_q;
    rise_d       = rise_q;
    ovf_d        = ovf_q;
    meas_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_h_d   = '0;
        acc_r_d   = '0;
        ovf_acc_d = '0;
        if (start || continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
        end
      end
      GATE: begin
        // saturating accumulate; a blocked increment marks the channel overflowed
        for (int i = 0; i < NUM_CH; i++) begin
          if (s[i]) begin
            if (acc_h_q[i] == CNT_MAX) ovf_acc_d[i] = 1'b1;
            else                       acc_h_d[i]   = acc_h_q[i] + CNT_W'(1);
          end
          if (s[i] && !prev_q[i]) begin
            if (acc_r_q[i] == CNT_MAX) ovf_acc_d[i] = 1'b1;
            else                       acc_r_d[i]   = acc_r_q[i] + CNT_W'(1);
          end
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d    = LATCH;
          gate_cnt_d = '0;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
        end
      end
      LATCH: begin
        high_d       = acc_h_q;
        rise_d       = acc_r_q;
        ovf_d        = ovf_acc_q;
        meas_valid_d = 1'b1;
        acc_h_d      = '0;
        acc_r_d      = '0;
        ovf_acc_d    = '0;
        gate_cnt_d   = '0;
        state_d      = continuous ? GATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      sync_q       <= '0;
      prev_q       <= '0;
      acc_h_q      <= '0;
      acc_r_q      <= '0;
      ovf_acc_q    <= '0;
      high_q       <= '0;
      rise_q       <= '0;
      ovf_q        <= '0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      acc_h_q      <= acc_h_d;
      acc_r_q      <= acc_r_d;
      ovf_acc_q    <= ovf_acc_d;
      high_q       <= high_d;
      rise_q       <= rise_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign busy       = busy_q;
  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_q;
  assign rise_cnt   = rise_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_duty_cycle_meter_mc.sv
// Directed bench for duty_cycle_meter_mc: a 32-bit-counter instance plus a
// 6-bit-counter instance sharing stimulus, used for the saturation case.
module tb_duty_cycle_meter_mc;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int CWS = 6;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [NCH-1:0] sig_in = '0;
  logic busy, meas_valid, busy_s, meas_valid_s;
  logic [NCH*CW-1:0]  high_cnt, rise_cnt;
  logic [NCH*CWS-1:0] high_s, rise_s;
  logic [NCH-1:0] ovf, ovf_s;

  int errors = 0;
  int checks = 0;
  int ph = 0;
  int mode [NCH];
  int n;

  always #5 sys_clk = ~sys_clk;

  duty_cycle_meter_mc #(.NUM_CH(NCH), .CNT_W(CW), .GATE_CYCLES(100), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy), .meas_valid(meas_valid), .high_cnt(high_cnt), .rise_cnt(rise_cnt), .ovf(ovf));

  duty_cycle_meter_mc #(.NUM_CH(NCH), .CNT_W(CWS), .GATE_CYCLES(100), .SYNC_STAGES(2)) dut_s (
    .sys_clk(sys_clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy_s), .meas_valid(meas_valid_s), .high_cnt(high_s), .rise_cnt(rise_s), .ovf(ovf_s));

  // mode: 0 low, 1 high, 2 period 10 / 5 high, 3 period 4 / 1 high, 4 driven by hand
  function automatic logic gen(int md, int t);
    case (md)
      1:       return 1'b1;
      2:       return (t % 10) < 5;
      3:       return (t % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] hc(int i);
    return high_cnt[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] rc(int i);
    return rise_cnt[i*CW +: CW];
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
    ph++;
    for (int i = 0; i < NCH; i++) begin
      if (mode[i] != 4) sig_in[i] = gen(mode[i], ph);
    end
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!meas_valid && cnt < 400);
  endtask

  task automatic count_strobes(int ncyc, output int k);
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (meas_valid) k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    mode = '{0, 0, 0, 0};
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_rise", rise_cnt, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // single shot: ch0 50%, ch1 high, ch2 low, ch3 25%
    mode = '{2, 1, 0, 3};
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_rise", busy, 1);
    wait_valid(n);
    chk("t1_latency", n, 101);
    chk("t1_h0", hc(0), 50);
    chk("t1_r0", rc(0), 10);
    chk("t2_h1", hc(1), 100);
    chk("t2_r1", rc(1), 0);
    chk("t2_h2", hc(2), 0);
    chk("t2_r2", rc(2), 0);
    chk("t2_h3", hc(3), 25);
    chk("t2_r3", rc(3), 25);
    chk("t1_ovf", ovf, 0);
    step();
    chk("t1_valid_drop", meas_valid, 0);
    chk("t1_busy_drop", busy, 0);
    count_strobes(150, n);
    chk("t1_no_extra", n, 0);
    chk("t1_hold_h0", hc(0), 50);

    // saturation on the 6-bit instance
    mode = '{1, 0, 0, 0};
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(n);
    chk("t4_valid_s", meas_valid_s, 1);
    chk("t4_h0_sat", high_s[5:0], 63);
    chk("t4_ovf0_sat", ovf_s[0], 1);
    chk("t4_h0_wide", hc(0), 100);
    chk("t4_ovf0_wide", ovf[0], 0);
    mode[0] = 0;
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(n);
    chk("t4_h0_clear", high_s[5:0], 0);
    chk("t4_ovf0_clear", ovf_s[0], 0);

    // continuous: three windows, drop continuous mid third
    mode = '{2, 1, 0, 3};
    repeat (8) step();
    continuous = 1'b1;
    step();
    chk("t3_busy", busy, 1);
    wait_valid(n);
    chk("t3_lat_w1", n, 101);
    chk("t3_w1_h0", hc(0), 50);
    chk("t3_w1_r3", rc(3), 25);
    wait_valid(n);
    chk("t3_spacing_w2", n, 101);
    chk("t3_w2_h0", hc(0), 50);
    chk("t3_w2_r0", rc(0), 10);
    chk("t3_w2_h3", hc(3), 25);
    count_strobes(50, n);
    chk("t3_mid_w3", n, 0);
    continuous = 1'b0;
    wait_valid(n);
    chk("t3_spacing_w3", n, 51);
    chk("t3_w3_h1", hc(1), 100);
    chk("t3_w3_r0", rc(0), 10);
    step();
    chk("t3_busy_end", busy, 0);
    count_strobes(150, n);
    chk("t3_no_w4", n, 0);

    // reset mid-window, then start during GATE ignored
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", meas_valid, 0);
    chk("t5_high", high_cnt, 0);
    chk("t5_rise", rise_cnt, 0);
    chk("t5_ovf", ovf, 0);
    count_strobes(150, n);
    chk("t5_no_strobe", n, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    start = 1'b1;
    step();
    start = 1'b0;
    count_strobes(250, n);
    chk("t5_one_strobe", n, 1);
    chk("t5_h0", hc(0), 50);

    // single-cycle pulses on ch2; the pulse near window end lands in window 2
    mode = '{0, 0, 4, 0};
    sig_in[2] = 1'b0;
    repeat (8) step();
    continuous = 1'b1;
    step();
    for (int m = 2; m <= 102; m++) begin
      step();
      sig_in[2] = (m == 20 || m == 40 || m == 60 || m == 100);
    end
    chk("t6_valid_w1", meas_valid, 1);
    chk("t6_r2_w1", rc(2), 3);
    chk("t6_h2_w1", hc(2), 3);
    chk("t6_h0_w1", hc(0), 0);
    continuous = 1'b0;
    wait_valid(n);
    chk("t6_spacing", n, 101);
    chk("t6_r2_w2", rc(2), 1);
    chk("t6_h2_w2", hc(2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
